// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: scoreboard-based RAW stall, EXE redirect flush,
// memory-busy freeze, plus a registered status FSM and saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int PIPE_DEPTH          = 3,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_dec_valid,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] i_dec_src1,
  input  logic                           i_dec_src1_used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] i_dec_src2,
  input  logic                           i_dec_src2_used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] i_dec_dst,
  input  logic                           i_dec_reg_wrt_en,
  input  logic                           i_exe_redirect,
  input  logic                           i_mem_busy,
  output logic                           o_pc_en,
  output logic                           o_fe_dec_en,
  output logic                           o_fe_dec_flush,
  output logic                           o_dec_exe_en,
  output logic                           o_dec_exe_flush,
  output logic [1:0]                     o_state,
  output logic [CNT_WIDTH-1:0]           o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL  = 2'b01,
    ST_FROZEN = 2'b10
  } state_t;

  localparam int W = REG_INDEX_BIT_WIDTH;

  logic [PIPE_DEPTH-1:0]        r_wv;
  logic [PIPE_DEPTH-1:0][W-1:0] r_dst;
  logic [PIPE_DEPTH-1:0]        w_match;
  logic                         w_hazard;
  logic                         w_issue;
  logic                         w_new_wv;
  logic [W-1:0]                 w_new_dst;
  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [CNT_WIDTH-1:0]         r_cnt;

  // Entry 0 is EXE; the last entry (WB) still counts since the regfile is read a cycle later.
  genvar g;
  generate
    for (g = 0; g < PIPE_DEPTH; g++) begin : g_match
      assign w_match[g] = r_wv[g] &
                          ((i_dec_src1_used & (r_dst[g] == i_dec_src1)) |
                           (i_dec_src2_used & (r_dst[g] == i_dec_src2)));
    end
  endgenerate

  assign w_hazard  = i_dec_valid & (|w_match);
  assign w_issue   = i_reset & ~i_mem_busy & ~i_exe_redirect & ~w_hazard;
  assign w_new_wv  = w_issue & i_dec_valid & i_dec_reg_wrt_en;
  assign w_new_dst = w_issue ? i_dec_dst : '0;

  always_comb begin
    o_pc_en         = 1'b0;
    o_fe_dec_en     = 1'b0;
    o_fe_dec_flush  = 1'b0;
    o_dec_exe_en    = 1'b0;
    o_dec_exe_flush = 1'b0;
    w_state_nxt     = ST_RUN;
    if (i_reset) begin
      if (i_mem_busy) begin
        w_state_nxt = ST_FROZEN;
      end else if (i_exe_redirect) begin
        o_pc_en         = 1'b1;
        o_fe_dec_en     = 1'b1;
        o_fe_dec_flush  = 1'b1;
        o_dec_exe_en    = 1'b1;
        o_dec_exe_flush = 1'b1;
      end else if (w_hazard) begin
        o_dec_exe_en    = 1'b1;
        o_dec_exe_flush = 1'b1;
        w_state_nxt     = ST_STALL;
      end else begin
        o_pc_en      = 1'b1;
        o_fe_dec_en  = 1'b1;
        o_dec_exe_en = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wv  <= '0;
      r_dst <= '0;
    end else if (!i_mem_busy) begin
      r_wv  <= {r_wv[PIPE_DEPTH-2:0], w_new_wv};
      r_dst <= {r_dst[PIPE_DEPTH-2:0], w_new_dst};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // Counts on the registered state, so it lags the stall/freeze decision by one edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset)                            r_cnt <= '0;
    else if (r_state != ST_RUN && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign o_state     = r_state;
  assign o_stall_cnt = r_cnt;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control unit for the in-order pipelined CPU.
- Generates the enable and flush controls for the PC register, the FE/DEC buffer and the DEC/EXE buffer.
- Tracks in-flight register writes in an internal scoreboard. It stalls decode on RAW hazards (no forwarding path exists), flushes on EXE-stage redirects, and freezes the whole front end while data memory is busy.
- Keeps an FSM status and a saturating stall-cycle counter for debug and performance.

Parameters:
REG_INDEX_BIT_WIDTH, 4, width of register indices
PIPE_DEPTH, 3, number of scoreboard entries, i.e. stages after DEC that still hold an uncommitted write (EXE, MEM, WB)
CNT_WIDTH, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-low reset
dec_valid  in  1  DEC stage holds a real instruction
dec_src1  in  REG_INDEX_BIT_WIDTH  DEC source 1 index
dec_src1_used  in  1  source 1 is read
dec_src2  in  REG_INDEX_BIT_WIDTH  DEC source 2 index
dec_src2_used  in  1  source 2 is read
dec_dst  in  REG_INDEX_BIT_WIDTH  DEC destination index
dec_reg_wrt_en  in  1  DEC instruction writes the register file
exe_redirect  in  1  EXE instruction redirects the PC (taken branch or jump)
mem_busy  in  1  data memory not ready; whole pipeline must hold
pc_en  out  1  PC register load enable
fe_dec_en  out  1  FE/DEC buffer enable
fe_dec_flush  out  1  FE/DEC buffer loads a bubble
dec_exe_en  out  1  DEC/EXE buffer enable
dec_exe_flush  out  1  DEC/EXE buffer loads a bubble
state  out  2  00 RUN, 01 STALL, 10 FROZEN (registered)
stall_cnt  out  CNT_WIDTH  saturating count of cycles with state != RUN

Behaviour:
- Scoreboard: PIPE_DEPTH entries of {wv, dst}. Entry 0 corresponds to EXE.
- hazard (combinational) = dec_valid & any matching entry, where an entry matches if its wv=1 and its dst equals dec_src1 with dec_src1_used=1, or equals dec_src2 with dec_src2_used=1. All indices, including 0, are compared.
- Output priority, evaluated combinationally every cycle:
  1. reset low: all enables 0, flushes 0.
  2. mem_busy: all enables 0, flushes 0. exe_redirect is ignored; EXE must hold it until unfrozen.
  3. exe_redirect: pc_en=1, fe_dec_en=1, fe_dec_flush=1, dec_exe_en=1, dec_exe_flush=1.
  4. hazard: pc_en=0, fe_dec_en=0, fe_dec_flush=0, dec_exe_en=1, dec_exe_flush=1 (bubble into EXE).
  5. Otherwise: all enables 1, flushes 0.
- Flush semantics: a buffer with flush=1 and en=1 loads a bubble at the clock edge.
- Scoreboard update on each rising edge:
  - reset low: all entries cleared (wv=0, dst=0).
  - mem_busy: entries hold.
  - Otherwise: entry[i] <= entry[i-1] for i>=1, and entry[0] <= {dec_valid & dec_reg_wrt_en, dec_dst} only when case 5 applies; else entry[0] <= {0, 0}.
  - The entry leaving the last position retires. The register file writes in WB and is read in DEC in a later cycle, so the WB entry still counts as a hazard.
- FSM, registered, next state from current-cycle inputs:
  - Reset → RUN.
  - mem_busy → FROZEN.
  - else hazard & !exe_redirect → STALL.
  - else → RUN.
  - A hazard lasts at most PIPE_DEPTH cycles for a given DEC instruction.
- stall_cnt: cleared by reset. Increments by 1 on each edge where the registered state != RUN. Saturates at all-ones and does not wrap.
- Reset mid-stall or mid-freeze: scoreboard, state and counter all clear on that edge. Outputs follow reset priority while reset is low.
- Simultaneous hazard and redirect: redirect wins. The hazarding DEC instruction is squashed, not stalled.

Test Plan:
- Reset: reset=0 for 2 cycles with arbitrary inputs → all enables and flushes 0. After release: state=00, stall_cnt=0, no hazard for any DEC source.
- RAW distance 1: issue dst=5 wrt_en=1, then next DEC src1=5 used → dec_exe_flush=1 and pc_en=0 for exactly 3 cycles. Proceeds on the 4th. stall_cnt=3 one cycle after RUN resumes.
- Redirect over hazard: DEC src2=7 hazard against in-flight dst=7, with exe_redirect=1 in the same cycle → pc_en=1 and both flushes=1. Next cycle state=RUN and entry[0].wv=0.
- Freeze: mem_busy=1 for 4 cycles while 2 writes are in flight → all enables 0 and state=10. Scoreboard unchanged, so the same hazard still reports after release. stall_cnt +4.
- Unused source: DEC src1=3 with dec_src1_used=0 while an in-flight dst=3 exists → no stall, all enables 1.
- Saturation: preload the stall condition long enough with CNT_WIDTH overridden to 4 → stall_cnt holds at 15.
